// File: rtl/int_controller.sv
// Prioritised edge-capturing interrupt controller for the four-phase sequencer.
// Latency: IRQ edge -> PENDING 1 cycle; request raised on the next UPDATE edge; ACK/RET take effect 1 cycle later.
// Backpressure: a request holds INTF and its vector until acknowledged; other sources stay pending (no nesting).
module int_controller #(
    parameter int         N        = 4,
    parameter logic [7:0] VEC_BASE = 8'hF0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   phase,
    input  logic [N-1:0] irq,
    input  logic         mask_wr,
    input  logic [N-1:0] mask_in,
    input  logic         int_ack,
    input  logic         int_ret,
    output logic         intf,
    output logic [7:0]   vector,
    output logic [N-1:0] pending,
    output logic         in_service
);
    localparam int         IDW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] PH_UPDATE = 2'b11;

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t         state;
    logic [N-1:0]   mask;
    logic [N-1:0]   irq_q;
    logic [N-1:0]   rise;
    logic [N-1:0]   elig;
    logic [N-1:0]   ack_clr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] win;
    logic           ack_take;

    assign rise     = irq & ~irq_q;
    assign elig     = pending & mask;
    assign ack_take = en && (state == REQUEST) && int_ack;

    // Scan from the top so the lowest eligible index is the last to be written.
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = IDW'(i);
            end
        end
    end

    always_comb begin
        ack_clr = '0;
        if (ack_take) begin
            ack_clr[id] = 1'b1;
        end
    end

    // Edge capture and mask run regardless of EN or state; a fresh edge beats the ACK clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~ack_clr) | rise;
            if (mask_wr) begin
                mask <= mask_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            id         <= '0;
            intf       <= 1'b0;
            vector     <= VEC_BASE;
            in_service <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (phase == PH_UPDATE && |elig) begin
                        id     <= win;
                        vector <= VEC_BASE + 8'(win);
                        intf   <= 1'b1;
                        state  <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (int_ack) begin
                        intf       <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (int_ret) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: a reference model checked every cycle plus literal spot checks.
module tb_int_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] phase;
    logic [3:0] irq;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       int_ret;
    logic       intf;
    logic [7:0] vector;
    logic [3:0] pending;
    logic       in_service;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int_controller #(.N(4), .VEC_BASE(8'hF0)) dut (
        .clk(clk), .rst(rst), .en(en), .phase(phase), .irq(irq),
        .mask_wr(mask_wr), .mask_in(mask_in), .int_ack(int_ack), .int_ret(int_ret),
        .intf(intf), .vector(vector), .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    // Reference model: a request is outstanding while m_intf is set, a routine runs while m_svc is set.
    logic [3:0] m_pend, m_mask, m_prev, np;
    logic       m_intf, m_svc;
    logic [7:0] m_vec;
    int         m_id;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 4'b0; m_mask = 4'b0; m_prev = 4'b0;
            m_intf = 1'b0; m_svc = 1'b0; m_vec = 8'hF0; m_id = 0;
        end else begin
            np = m_pend;
            if (en) begin
                if (!m_intf && !m_svc) begin
                    if (phase == 2'd3 && (m_pend & m_mask) != 4'b0) begin
                        m_id   = lowest(m_pend & m_mask);
                        m_vec  = 8'hF0 + 8'(m_id);
                        m_intf = 1'b1;
                    end
                end else if (m_intf) begin
                    if (int_ack) begin
                        np[m_id] = 1'b0;
                        m_intf   = 1'b0;
                        m_svc    = 1'b1;
                    end
                end else if (int_ret) begin
                    m_svc = 1'b0;
                end
            end
            np     = np | (irq & ~m_prev);
            m_pend = np;
            m_prev = irq;
            if (mask_wr) m_mask = mask_in;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_intf", 8'(intf), 8'(m_intf));
            chk("model_vector", vector, m_vec);
            chk("model_pending", 8'(pending), 8'(m_pend));
            chk("model_in_service", 8'(in_service), 8'(m_svc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        phase = phase + 2'd1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next edge will sample phase p (bounded to one full rotation).
    task automatic to_phase(input logic [1:0] p);
        for (int i = 0; i < 4 && phase != p; i++) tick();
    endtask

    task automatic ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic ret();
        int_ret = 1'b1; tick(); int_ret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; phase = 2'd0; irq = 4'b0; mask_wr = 1'b0;
        mask_in = 4'b0; int_ack = 1'b0; int_ret = 1'b0;
        run(2);
        chk("rst_intf", 8'(intf), 8'h00);
        chk("rst_pending", 8'(pending), 8'h00);
        chk("rst_vector", vector, 8'hF0);
        chk("rst_in_service", 8'(in_service), 8'h00);
        rst = 1'b0;
        chk_en = 1'b1;

        // Masked source only pends.
        irq = 4'b0100; tick(); irq = 4'b0000; tick();
        chk("masked_pending", 8'(pending), 8'h04);
        run(8);
        chk("masked_no_intf", 8'(intf), 8'h00);

        // Basic request/service: source 1 beats the already-pending source 2.
        to_phase(2'd0);
        mask_wr = 1'b1; mask_in = 4'b1111; irq = 4'b0010; tick();
        mask_wr = 1'b0; irq = 4'b0000;
        run(2);
        chk("pre_update_intf", 8'(intf), 8'h00);
        tick();
        chk("basic_intf", 8'(intf), 8'h01);
        chk("basic_vector", vector, 8'hF1);
        ack();
        chk("ack_intf", 8'(intf), 8'h00);
        chk("ack_pending", 8'(pending), 8'h04);
        chk("ack_in_service", 8'(in_service), 8'h01);
        ret();
        chk("ret_in_service", 8'(in_service), 8'h00);

        // Freeze during request for source 2.
        to_phase(2'd3); tick();
        chk("freeze_start_vector", vector, 8'hF2);
        irq = 4'b0001; mask_wr = 1'b1; mask_in = 4'b1011; tick();
        irq = 4'b0000; mask_wr = 1'b0;
        run(5);
        chk("freeze_vector", vector, 8'hF2);
        chk("freeze_intf", 8'(intf), 8'h01);
        ack();
        chk("freeze_pending", 8'(pending), 8'h01);
        ret();
        to_phase(2'd3); tick();
        chk("after_freeze_vector", vector, 8'hF0);
        ack(); ret();
        mask_wr = 1'b1; mask_in = 4'b1111; tick(); mask_wr = 1'b0;

        // Priority between simultaneous edges.
        to_phase(2'd0);
        irq = 4'b1001; tick(); irq = 4'b0000;
        to_phase(2'd3); tick();
        chk("prio_first", vector, 8'hF0);
        ack(); ret();
        to_phase(2'd3); tick();
        chk("prio_second", vector, 8'hF3);
        ack(); ret();

        // Re-edge during ACK keeps the bit; held level yields a single event.
        irq = 4'b0010; tick(); irq = 4'b0000;
        to_phase(2'd3); tick();
        chk("setclr_vector", vector, 8'hF1);
        irq = 4'b0010;
        ack();
        chk("setclr_pending", 8'(pending), 8'h02);
        ret();
        to_phase(2'd3); tick();
        chk("held_intf", 8'(intf), 8'h01);
        ack();
        run(12);
        chk("held_pending", 8'(pending), 8'h00);
        chk("held_in_service", 8'(in_service), 8'h01);
        irq = 4'b0000;

        // Reset in SERVICE.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_in_service", 8'(in_service), 8'h00);
        chk("midrst_vector", vector, 8'hF0);
        chk("midrst_pending", 8'(pending), 8'h00);

        // EN freeze.
        mask_wr = 1'b1; mask_in = 4'b1111; irq = 4'b0100; tick();
        mask_wr = 1'b0; irq = 4'b0000; en = 1'b0;
        to_phase(2'd3); tick();
        chk("en0_intf", 8'(intf), 8'h00);
        run(3);
        en = 1'b1; tick();
        chk("en1_intf", 8'(intf), 8'h01);
        chk("en1_vector", vector, 8'hF2);
        en = 1'b0; int_ack = 1'b1; tick();
        chk("en0_ack_intf", 8'(intf), 8'h01);
        en = 1'b1; tick(); int_ack = 1'b0;
        chk("en1_ack_svc", 8'(in_service), 8'h01);
        ret();
        int_ack = 1'b1; int_ret = 1'b1; tick(); int_ack = 1'b0; int_ret = 1'b0;
        chk("idle_ignore", 8'(in_service), 8'h00);
        run(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/int_controller.md
# int_controller

Prioritised interrupt controller for the four-phase processor. It captures rising edges on external interrupt lines and applies a software-writable enable mask. At the UPDATE phase reported by the phaser it raises INTF toward the sequencer, then holds the serviced source's vector until the sequencer acknowledges entry and signals return from the service routine. It sits between the external IRQ pins, the phaser, and the sequencer's INTF input.

## Interface
- N, 4, number of interrupt sources (1..8)
- VEC_BASE, 8'hF0, base vector address; VECTOR = VEC_BASE + source index
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  synchronous, active-high reset
- EN  input  1  controller enable; low freezes the state machine, edge capture continues
- PHASE  input  2  phaser output: FETCH=00, DECODE=01, EXEC=10, UPDATE=11
- IRQ  input  N  external interrupt lines, rising-edge sensitive, synchronous to CLK
- MASK_WR  input  1  load MASK_IN into enable mask this cycle
- MASK_IN  input  N  new enable mask; bit=1 enables that source
- INT_ACK  input  1  sequencer has vectored to the service routine
- INT_RET  input  1  sequencer executed return-from-interrupt
- INTF  output  1  interrupt request to sequencer
- VECTOR  output  8  vector of the source being requested or serviced
- PENDING  output  N  latched, not-yet-acknowledged edges
- IN_SERVICE  output  1  a service routine is active

## Operation
- Reset (RST=1 at an edge): PENDING=0, mask=0 (all disabled), IRQ history=0, state=IDLE, INTF=0, VECTOR=VEC_BASE, IN_SERVICE=0. Reset overrides every other input, including mid-request or mid-service.
- Edge capture runs every cycle regardless of EN or state:
  - PENDING[i] sets when IRQ[i]=1 and the previous sample was 0.
  - Because history resets to 0, an IRQ held high through reset release counts as one edge.
  - A level held high produces only one pending event.
- Eligible set = PENDING & mask. Priority is fixed: lowest index wins.
- IDLE:
  - Transitions when EN=1, PHASE=UPDATE and the eligible set is non-zero.
  - Latches the winning index id, drives VECTOR=VEC_BASE+id, sets INTF=1, moves to REQUEST.
- REQUEST:
  - INTF stays 1 and id is frozen; new edges or mask changes do not alter id.
  - On EN=1 and INT_ACK=1: clear PENDING[id], INTF=0, IN_SERVICE=1, move to SERVICE.
- SERVICE:
  - Holds VECTOR. No nesting: further eligible sources wait.
  - On EN=1 and INT_RET=1: IN_SERVICE=0, move to IDLE.
  - Re-arbitration in IDLE happens at the next UPDATE phase, not the same cycle.
- INT_ACK outside REQUEST and INT_RET outside SERVICE are ignored.
- Simultaneous new edge on IRQ[id] and INT_ACK clearing PENDING[id]: the set wins, and the bit remains pending.
- MASK_WR takes effect at the next edge, in any state. Masking a pending source does not clear PENDING.
- EN=0: state, INTF, VECTOR and IN_SERVICE hold. PENDING and mask still update.

## Timing
- IRQ rising at edge k (first sample high) -> PENDING set after edge k.
- INTF asserts after the first edge with PHASE=11 and a non-zero eligible set. Best-case IRQ-to-INTF latency is 2 cycles; worst case is 5 (edge just after UPDATE).
- INTF deasserts and IN_SERVICE asserts 1 cycle after INT_ACK is sampled.
- IN_SERVICE deasserts 1 cycle after INT_RET is sampled. The earliest next INTF is the following UPDATE edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset and idle:
  - Stimulus: RST=1 for 2 cycles with IRQ=4'b0000.
  - Required: INTF=0, PENDING=0, VECTOR=8'hF0, IN_SERVICE=0.
  - Stimulus: pulse IRQ[2] while mask=0.
  - Required: PENDING=4'b0100, INTF stays 0 across 8 phases.
- Basic request and service:
  - Stimulus: mask=4'b1111, IRQ[1] rises during FETCH.
  - Required: INTF=1 after the UPDATE edge, VECTOR=8'hF1.
  - Stimulus: INT_ACK.
  - Required: INTF=0, PENDING[1]=0, IN_SERVICE=1.
  - Stimulus: INT_RET.
  - Required: IN_SERVICE=0.
- Priority:
  - Stimulus: IRQ[3] and IRQ[0] rise in the same cycle.
  - Required: first VECTOR=8'hF0. After ACK and RET, the next UPDATE gives VECTOR=8'hF3.
- Freeze during request:
  - Stimulus: in REQUEST for id=2, IRQ[0] rises and MASK_WR clears bit 2.
  - Required: VECTOR stays 8'hF2 and INTF stays 1 until INT_ACK. PENDING=4'b0001 after ACK.
- Simultaneous set/clear and held level:
  - Stimulus: re-edge IRQ[1] in the ACK cycle for id=1.
  - Required: PENDING[1]=1 after ACK.
  - Stimulus: hold IRQ[1] high for 20 cycles.
  - Required: only one pending event.
- Reset mid-service and EN freeze:
  - Stimulus: RST in SERVICE.
  - Required: IDLE with all outputs at reset values next cycle.
  - Stimulus: EN=0 during UPDATE with an eligible source.
  - Required: INTF stays 0 until an UPDATE with EN=1.
